// File: rtl/cam_search_engine.sv
// Parametrised BCAM/TCAM with valid bits and a 2-stage search pipeline.
// Results are priority encoded; hit_count tracks hit results.
module cam_search_engine #(
    parameter int CAM_DEPTH = 8,
    parameter int CAM_WIDTH = 8,
    parameter     CAM_TYPE  = "BCAM",
    parameter int CNT_WIDTH = 16,
    localparam int AW = $clog2(CAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [CAM_WIDTH-1:0] wr_key,
    input  logic [CAM_WIDTH-1:0] wr_mask,
    input  logic                 wr_valid,
    input  logic                 flush,
    input  logic                 search_valid,
    output logic                 search_ready,
    input  logic [CAM_WIDTH-1:0] search_key,
    input  logic [CAM_WIDTH-1:0] search_mask,
    output logic                 result_valid,
    output logic                 result_hit,
    output logic [AW-1:0]        result_addr,
    output logic                 result_multi,
    output logic [CAM_DEPTH-1:0] result_vec,
    output logic [CNT_WIDTH-1:0] hit_count
);

    localparam bit TCAM = (CAM_TYPE == "TCAM");

    logic [CAM_WIDTH-1:0] tbl_key  [CAM_DEPTH];
    logic [CAM_WIDTH-1:0] tbl_mask [CAM_DEPTH];
    logic [CAM_DEPTH-1:0] tbl_valid;

    logic                 addr_ok;
    logic                 wr_hit;
    logic                 accept;

    logic                 s1_valid;
    logic [CAM_WIDTH-1:0] s1_key;
    logic [CAM_WIDTH-1:0] s1_mask;
    logic [CAM_DEPTH-1:0] cmp_vec;

    logic                 s2_valid;
    logic [CAM_DEPTH-1:0] s2_vec;

    logic                 enc_hit;
    logic                 enc_multi;
    logic [AW-1:0]        enc_addr;

    assign addr_ok      = (32'(wr_addr) < 32'(CAM_DEPTH));
    assign wr_hit       = wr_en && !flush && addr_ok;
    assign search_ready = rst && !flush;
    assign accept       = search_valid && search_ready;

    // Key/mask storage; BCAM keeps an all-zero mask so it never masks.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            tbl_key[wr_addr]  <= wr_key;
            tbl_mask[wr_addr] <= TCAM ? wr_mask : '0;
        end
    end

    // Valid bits: flush clears all and overrides a concurrent write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tbl_valid <= '0;
        end else if (flush) begin
            tbl_valid <= '0;
        end else if (wr_hit) begin
            tbl_valid[wr_addr] <= wr_valid;
        end
    end

    // S1: capture the accepted request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_key   <= '0;
            s1_mask  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_key  <= search_key;
                s1_mask <= search_mask;
            end
        end
    end

    // Compare the S1 key against the current (pre-write) table.
    always_comb begin
        cmp_vec = '0;
        for (int i = 0; i < CAM_DEPTH; i++) begin
            cmp_vec[i] = tbl_valid[i] &&
                (((tbl_key[i] ^ s1_key) & ~s1_mask & ~tbl_mask[i]) == '0);
        end
    end

    // S2: register the raw match vector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_vec   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_vec <= cmp_vec;
            end
        end
    end

    // Priority encode: lowest set index wins; multi when >1 bit set.
    always_comb begin
        enc_addr  = '0;
        enc_hit   = |s2_vec;
        enc_multi = |(s2_vec & (s2_vec - 1'b1));
        for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
            if (s2_vec[i]) begin
                enc_addr = AW'(i);
            end
        end
    end

    // Output registers hold between pulses; hit counter saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_valid <= 1'b0;
            result_hit   <= 1'b0;
            result_addr  <= '0;
            result_multi <= 1'b0;
            result_vec   <= '0;
            hit_count    <= '0;
        end else begin
            result_valid <= s2_valid;
            if (s2_valid) begin
                result_hit   <= enc_hit;
                result_addr  <= enc_addr;
                result_multi <= enc_multi;
                result_vec   <= s2_vec;
                if (enc_hit && !(&hit_count)) begin
                    hit_count <= hit_count + 1'b1;
                end
            end
        end
    end

endmodule
